// File: rtl/sevenseg_pkg.sv
// Shared register map, field indices and converter types for the seven-segment BCD controller.
package sevenseg_pkg;

  localparam int unsigned MAX_DEC_DEFAULT   = 9999;
  localparam int unsigned CONV_BITS_DEFAULT = 14;
  localparam int unsigned BCD_W             = 16;
  localparam int unsigned NIBBLES           = 4;

  localparam logic [1:0] REG_VALUE  = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int unsigned CTRL_DEC_BIT    = 0;
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_SAT_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_e;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sevenseg_bcd_ctrl_bin2bcd.sv
// Iterative binary-to-BCD converter: one double-dabble step per cycle, restartable and abortable.
module bin2bcd_iter
  import sevenseg_pkg::*;
#(
  parameter int unsigned CONV_BITS = CONV_BITS_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CONV_BITS-1:0] operand,
  output logic                 busy,
  output logic                 done,
  output logic [BCD_W-1:0]     bcd
);

  localparam int unsigned SR_W  = BCD_W + CONV_BITS;
  localparam int unsigned CNT_W = $clog2(CONV_BITS + 1);

  conv_state_e      state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [SR_W-1:0]  sr_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_iter;

  assign last_iter = (cnt_q == CNT_W'(CONV_BITS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A start always reloads, even mid-conversion or in the commit cycle.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = SHIFT;
    end else if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        SHIFT:   state_d = last_iter ? COMMIT : SHIFT;
        COMMIT:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    sr_adj = {bcd_adjust(sr_q[SR_W-1 -: BCD_W]), sr_q[CONV_BITS-1:0]};
    if (start) begin
      sr_d  = {BCD_W'(0), operand};
      cnt_d = '0;
    end else if (!abort && state_q == SHIFT) begin
      sr_d  = {sr_adj[SR_W-2:0], 1'b0};
      cnt_d = cnt_q + CNT_W'(1);
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == COMMIT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/sevenseg_bcd_ctrl.sv
// Wishbone slave holding VALUE/CTRL/STATUS and driving the scanner nibble word, raw or via BCD conversion.
module sevenseg_bcd_ctrl
  import sevenseg_pkg::*;
#(
  parameter int unsigned MAX_DEC   = MAX_DEC_DEFAULT,
  parameter int unsigned CONV_BITS = CONV_BITS_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [15:0] disp_o
);

  logic                 req_c, wr_c, rd_c, commit_c, over_c;
  logic                 start_c, abort_c;
  logic [1:0]           reg_sel;
  logic [15:0]          value_q, value_d;
  logic                 dec_q, dec_d;
  logic                 sat_q;
  logic [15:0]          disp_q;
  logic                 ack_q;
  logic [31:0]          dat_q, rdata_c;
  logic [CONV_BITS-1:0] operand_c;
  logic                 conv_busy, conv_done;
  logic [BCD_W-1:0]     conv_bcd;
  logic                 unused_c;

  assign unused_c = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i[3:2], wb_dat_i[31:16]};

  // The ack flop itself blocks a held request from being acked twice in a row.
  assign req_c    = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_c     = req_c & wb_we_i;
  assign rd_c     = req_c & ~wb_we_i;
  assign reg_sel  = wb_adr_i[3:2];
  assign commit_c = wr_c & ((reg_sel == REG_VALUE) | (reg_sel == REG_CTRL));

  always_comb begin
    value_d = value_q;
    dec_d   = dec_q;
    if (wr_c && reg_sel == REG_VALUE) begin
      if (wb_sel_i[0]) value_d[7:0]  = wb_dat_i[7:0];
      if (wb_sel_i[1]) value_d[15:8] = wb_dat_i[15:8];
    end
    if (wr_c && reg_sel == REG_CTRL && wb_sel_i[0]) begin
      dec_d = wb_dat_i[CTRL_DEC_BIT];
    end
  end

  // Commit decisions use the post-write register contents.
  assign over_c    = (32'(value_d) > MAX_DEC);
  assign operand_c = over_c ? CONV_BITS'(MAX_DEC) : value_d[CONV_BITS-1:0];
  assign start_c   = commit_c & dec_d;
  assign abort_c   = commit_c & ~dec_d;

  always_comb begin
    rdata_c = '0;
    case (reg_sel)
      REG_VALUE:  rdata_c[15:0] = value_q;
      REG_CTRL:   rdata_c[CTRL_DEC_BIT] = dec_q;
      REG_STATUS: begin
        rdata_c[STATUS_BUSY_BIT] = conv_busy;
        rdata_c[STATUS_SAT_BIT]  = sat_q;
      end
      default:    rdata_c = '0;
    endcase
  end

  bin2bcd_iter #(
    .CONV_BITS (CONV_BITS)
  ) u_bin2bcd (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (start_c),
    .abort   (abort_c),
    .operand (operand_c),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  // A commit event outranks a conversion finishing in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      value_q <= '0;
      dec_q   <= 1'b0;
      sat_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      ack_q   <= req_c;
      dat_q   <= rd_c ? rdata_c : '0;
      value_q <= value_d;
      dec_q   <= dec_d;
      if (commit_c) begin
        sat_q <= dec_d & over_c;
        if (!dec_d) disp_q <= value_d;
      end else if (conv_done) begin
        disp_q <= conv_bcd;
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign disp_o   = disp_q;

endmodule

// File: tb/tb_sevenseg_bcd_ctrl.sv
// Directed bench for sevenseg_bcd_ctrl with a queue of expected display words.
module tb_sevenseg_bcd_ctrl;
  import sevenseg_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [15:0] disp_o;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] forbid = 16'h0000;
  logic        forbid_en = 1'b0;
  int          bad_seen = 0;

  always #5 clk_i = ~clk_i;

  sevenseg_bcd_ctrl dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .disp_o   (disp_o)
  );

  always @(disp_o) begin
    if (forbid_en && disp_o === forbid) bad_seen++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = '0;
    wb_sel_i = '0;
    wb_dat_i = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_adr_i = {28'h0, a, 2'b00};
    wb_sel_i = s;
    wb_dat_i = d;
    tick();
    chk("wr_ack", 32'(wb_ack_o), 32'd1);
    bus_idle();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b0;
    wb_adr_i = {28'h0, a, 2'b00};
    wb_sel_i = 4'hF;
    tick();
    chk("rd_ack", 32'(wb_ack_o), 32'd1);
    d = wb_dat_o;
    bus_idle();
  endtask

  task automatic pop_chk(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(disp_o), 32'(e));
    end
  endtask

  // Decimal write of VALUE with BUSY probed near both ends of the 15-cycle window.
  task automatic dec_write(input logic [15:0] v, input logic [15:0] e, input logic s,
                           input logic [15:0] old);
    logic [31:0] st;
    wr(REG_VALUE, 32'(v), 4'h3);
    exp_q.push_back(e);
    tick();
    rd(REG_STATUS, st);
    chk("busy_early", st, {30'h0, s, 1'b1});
    repeat (12) tick();
    chk("no_partial", 32'(disp_o), 32'(old));
    rd(REG_STATUS, st);
    chk("busy_last", 32'(st[0]), 32'd1);
    pop_chk("dec_disp");
    tick();
    rd(REG_STATUS, st);
    chk("busy_done", st, {30'h0, s, 1'b0});
    tick();
  endtask

  initial begin
    logic [31:0] d;
    rst_i = 1'b1;
    bus_idle();
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_disp", 32'(disp_o), 32'h0);
    chk("rst_ack", 32'(wb_ack_o), 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    tick();
    rd(REG_VALUE, d);  chk("rst_value", d, 32'h0);  tick();
    rd(REG_CTRL, d);   chk("rst_ctrl", d, 32'h0);   tick();
    rd(REG_STATUS, d); chk("rst_status", d, 32'h0); tick();
    rd(2'd3, d);       chk("reg3_read", d, 32'h0);  tick();

    // Raw mode: display follows VALUE in the ack cycle, converter untouched.
    wr(REG_VALUE, 32'h1234_BEEF, 4'hF);
    exp_q.push_back(16'hBEEF);
    pop_chk("raw_beef");
    tick();
    rd(REG_STATUS, d); chk("raw_status", d, 32'h0); tick();
    rd(REG_VALUE, d);  chk("raw_value", d, 32'h0000_BEEF); tick();

    // Switching to decimal starts a conversion that the VALUE write then restarts.
    wr(REG_CTRL, 32'h1, 4'h1);
    tick();
    rd(REG_CTRL, d); chk("ctrl_dec", d, 32'h1);
    tick();
    dec_write(16'd1234, 16'h1234, 1'b0, 16'hBEEF);

    // A request held through the ack cycle is acked again only after a gap.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h4;
    tick(); chk("held_ack1", 32'(wb_ack_o), 32'd1);
    tick(); chk("no_reack", 32'(wb_ack_o), 32'd0);
    tick(); chk("held_ack2", 32'(wb_ack_o), 32'd1);
    bus_idle();
    tick();

    dec_write(16'd12000, 16'h9999, 1'b1, 16'h1234);
    dec_write(16'd42, 16'h0042, 1'b0, 16'h9999);

    // Second write during SHIFT discards the first conversion.
    forbid = 16'h5678; forbid_en = 1'b1;
    wr(REG_VALUE, 32'd5678, 4'h3);
    repeat (5) tick();
    wr(REG_VALUE, 32'd321, 4'h3);
    exp_q.push_back(16'h0321);
    repeat (14) tick();
    chk("restart_hold", 32'(disp_o), 32'h0042);
    tick();
    pop_chk("restart_disp");
    chk("restart_forbid", 32'(bad_seen), 32'd0);
    forbid_en = 1'b0;
    tick();

    // Write landing in the COMMIT cycle wins over the finishing conversion.
    forbid = 16'h0100; forbid_en = 1'b1;
    wr(REG_VALUE, 32'd100, 4'h3);
    repeat (14) tick();
    wr(REG_VALUE, 32'd7, 4'h3);
    chk("commit_prio", 32'(disp_o), 32'h0321);
    exp_q.push_back(16'h0007);
    repeat (15) tick();
    pop_chk("commit_prio_disp");
    chk("commit_forbid", 32'(bad_seen), 32'd0);
    forbid_en = 1'b0;
    tick();

    // Raw commit on the last SHIFT edge aborts the conversion.
    wr(REG_VALUE, 32'd255, 4'h3);
    repeat (13) tick();
    wr(REG_CTRL, 32'h0, 4'h1);
    exp_q.push_back(16'h00FF);
    pop_chk("raw_abort");
    repeat (4) tick();
    chk("no_late_commit", 32'(disp_o), 32'h00FF);
    rd(REG_STATUS, d); chk("abort_status", d, 32'h0); tick();

    // SAT set by a saturating decimal commit, cleared by a raw commit.
    wr(REG_CTRL, 32'h1, 4'h1);
    tick();
    wr(REG_VALUE, 32'd12000, 4'h3);
    tick();
    rd(REG_STATUS, d); chk("sat_busy", d, 32'h3); tick();
    wr(REG_CTRL, 32'h0, 4'h1);
    exp_q.push_back(16'h2EE0);
    pop_chk("raw_12000");
    tick();
    rd(REG_STATUS, d); chk("sat_clear", d, 32'h0); tick();

    // Byte lanes: sel[3:2] ignored; register 3 writes ignored.
    wr(REG_VALUE, 32'hFFFF_12AB, 4'b0001);
    exp_q.push_back(16'h2EAB);
    pop_chk("lane0");
    tick();
    wr(REG_VALUE, 32'h0000_CD00, 4'b1110);
    exp_q.push_back(16'hCDAB);
    pop_chk("lane1");
    tick();
    wr(2'd3, 32'hFFFF_FFFF, 4'hF);
    chk("reg3_nowrite", 32'(disp_o), 32'hCDAB);
    tick();
    rd(REG_VALUE, d); chk("lane_value", d, 32'h0000_CDAB); tick();

    // Reset mid-conversion, colliding with a read request.
    wr(REG_CTRL, 32'h1, 4'h1);
    repeat (3) tick();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    bus_idle();
    chk("mid_rst_disp", 32'(disp_o), 32'h0);
    chk("mid_rst_ack", 32'(wb_ack_o), 32'h0);
    chk("mid_rst_dat", wb_dat_o, 32'h0);
    tick();
    rd(REG_STATUS, d); chk("mid_rst_status", d, 32'h0); tick();
    rd(REG_CTRL, d);   chk("mid_rst_ctrl", d, 32'h0);   tick();
    rd(REG_VALUE, d);  chk("mid_rst_value", d, 32'h0);
    repeat (20) tick();
    chk("mid_rst_nocommit", 32'(disp_o), 32'h0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
